i2c_reg_sequencer: RTL and testbench

Register-access sequencer for the I2C master core (`i2c_control`). It accepts one register read or write request at a time and expands it into the core's primitive command sequence: START, address and register bytes, optional repeated START, data byte, STOP. It checks the core's ACK status at every byte and returns read data plus an error code. It sits between user logic (switch/key front end, configuration ROM walkers) and the core, replacing hand-driven `control` pulses.

---
 rtl/i2c_reg_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// Register read/write sequencer for the i2c_control core: expands one request into START/WRITE/READ/STOP steps.
// Optional address-NACK retry is built in when I2C_SEQ_RETRY_EN is defined.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned RETRIES        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] core_cmd,
  output logic [7:0] core_wdata,
  input  logic       core_busy,
  input  logic       core_nack,
  input  logic [7:0] core_rdata
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_STOP      = 3'd2;
  localparam logic [2:0] CMD_WRITE     = 3'd3;
  localparam logic [2:0] CMD_READ_ACK  = 3'd4;
  localparam logic [2:0] CMD_READ_NACK = 3'd5;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    IDLE, ISSUE, WAIT_START, WAIT_DONE, CHECK, ABORT, ABORT_START, ABORT_DONE, RESP
  } state_t;

  state_t        state;
  logic [2:0]    step;
  logic          rw;
  logic [6:0]    dev;
  logic [7:0]    reg_addr;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic [TW-1:0] timer;

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned RCW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  logic [RCW-1:0] retry_cnt;
  logic           retry_pend;
`endif

  // Step lists: write = S,W,W,W,P ; read = S,W,W,S,W,RN,P
  function automatic logic [2:0] step_cmd(input logic is_read, input logic [2:0] s);
    logic [2:0] c;
    c = CMD_STOP;
    if (is_read) begin
      case (s)
        3'd0, 3'd3:       c = CMD_START;
        3'd1, 3'd2, 3'd4: c = CMD_WRITE;
        3'd5:             c = CMD_READ_NACK;
        default:          c = CMD_STOP;
      endcase
    end else begin
      case (s)
        3'd0:             c = CMD_START;
        3'd1, 3'd2, 3'd3: c = CMD_WRITE;
        default:          c = CMD_STOP;
      endcase
    end
    return c;
  endfunction

  function automatic logic [7:0] step_byte(input logic is_read, input logic [2:0] s,
                                           input logic [6:0] d, input logic [7:0] r,
                                           input logic [7:0] w);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      3'd1:    b = {d, 1'b0};
      3'd2:    b = r;
      3'd3:    b = is_read ? 8'h00 : w;
      3'd4:    b = is_read ? {d, 1'b1} : 8'h00;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [2:0] cur_cmd;
  logic [2:0] nxt_cmd;
  logic [7:0] nxt_byte;
  logic       waiting;
  logic       wait_met;
  logic       timed_out;

  always_comb begin
    cur_cmd   = step_cmd(rw, step);
    nxt_cmd   = step_cmd(rw, 3'(step + 3'd1));
    nxt_byte  = step_byte(rw, 3'(step + 3'd1), dev, reg_addr, wdata);
    waiting   = (state == WAIT_START) || (state == WAIT_DONE) ||
                (state == ABORT_START) || (state == ABORT_DONE);
    wait_met  = ((state == WAIT_START) || (state == ABORT_START)) ? core_busy : !core_busy;
    timed_out = (timer <= TW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step       <= 3'd0;
      rw         <= 1'b0;
      dev        <= 7'h00;
      reg_addr   <= 8'h00;
      wdata      <= 8'h00;
      rdata      <= 8'h00;
      timer      <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_err    <= ERR_OK;
      core_cmd   <= CMD_NONE;
      core_wdata <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
`endif
    end else begin
      core_cmd  <= CMD_NONE;
      rsp_valid <= 1'b0;
      // A hung core gets no STOP: report timeout straight away.
      if (waiting && !wait_met && timed_out) begin
        timer     <= '0;
        rsp_valid <= 1'b1;
        rsp_err   <= ERR_TIMEOUT;
        rsp_rdata <= 8'h00;
        state     <= RESP;
      end else begin
        unique case (state)
          IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready) begin
              req_ready  <= 1'b0;
              rw         <= req_rw;
              dev        <= req_dev;
              reg_addr   <= req_reg;
              wdata      <= req_wdata;
              rdata      <= 8'h00;
              step       <= 3'd0;
              core_cmd   <= CMD_START;
              core_wdata <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
              retry_cnt  <= '0;
              retry_pend <= 1'b0;
`endif
              state      <= ISSUE;
            end
          end
          ISSUE: begin
            timer <= TW'(TIMEOUT_CYCLES);
            state <= WAIT_START;
          end
          WAIT_START: begin
            timer <= timer - TW'(1);
            if (wait_met) state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            timer <= timer - TW'(1);
            if (wait_met) state <= CHECK;
          end
          CHECK: begin
            if (cur_cmd == CMD_READ_ACK || cur_cmd == CMD_READ_NACK) rdata <= core_rdata;
            if (cur_cmd == CMD_WRITE && core_nack) begin
              core_cmd   <= CMD_STOP;
              core_wdata <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
              retry_pend <= (step == 3'd1) && (retry_cnt < RCW'(RETRIES));
`endif
              state      <= ABORT;
            end else if (cur_cmd == CMD_STOP) begin
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_OK;
              rsp_rdata <= rdata;
              state     <= RESP;
            end else begin
              step       <= 3'(step + 3'd1);
              core_cmd   <= nxt_cmd;
              core_wdata <= nxt_byte;
              state      <= ISSUE;
            end
          end
          ABORT: begin
            timer <= TW'(TIMEOUT_CYCLES);
            state <= ABORT_START;
          end
          ABORT_START: begin
            timer <= timer - TW'(1);
            if (wait_met) state <= ABORT_DONE;
          end
          ABORT_DONE: begin
            timer <= timer - TW'(1);
            if (wait_met) begin
`ifdef I2C_SEQ_RETRY_EN
              if (retry_pend) begin
                retry_pend <= 1'b0;
                retry_cnt  <= retry_cnt + RCW'(1);
                step       <= 3'd0;
                core_cmd   <= CMD_START;
                core_wdata <= 8'h00;
                state      <= ISSUE;
              end else begin
                rsp_valid <= 1'b1;
                rsp_err   <= ERR_NACK;
                rsp_rdata <= 8'h00;
                state     <= RESP;
              end
`else
              rsp_valid <= 1'b1;
              rsp_err   <= ERR_NACK;
              rsp_rdata <= 8'h00;
              state     <= RESP;
`endif
            end
          end
          RESP: begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural I2C core model, command/response scoreboard, vector table.
module tb_i2c_reg_sequencer;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned RETRIES = 3;
`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [2:0] C_START = 3'd1;
  localparam logic [2:0] C_STOP  = 3'd2;
  localparam logic [2:0] C_WRITE = 3'd3;
  localparam logic [2:0] C_RNACK = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] core_cmd;
  logic [7:0] core_wdata;
  logic       core_busy;
  logic       core_nack;
  logic [7:0] core_rdata;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .RETRIES(RETRIES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .core_cmd(core_cmd), .core_wdata(core_wdata),
    .core_busy(core_busy), .core_nack(core_nack), .core_rdata(core_rdata)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string cur_tag = "reset";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h, want 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  // Core model: busy for busy_len cycles after each command, NACKs writes selected by ordinal.
  int          busy_len = 1;
  bit          hang = 1'b0;
  logic [31:0] nack_mask = 32'h0;
  logic [7:0]  model_rdata = 8'h00;
  int          busy_left;
  int          wr_ord;

  assign core_rdata = model_rdata;

  always @(posedge clk) begin
    if (reset) begin
      core_busy <= 1'b0;
      core_nack <= 1'b0;
      busy_left <= 0;
      wr_ord    <= 0;
    end else begin
      if (req_valid && req_ready) wr_ord <= 0;
      if (core_cmd != 3'd0) begin
        core_busy <= 1'b1;
        busy_left <= busy_len - 1;
        if (core_cmd == C_WRITE) begin
          core_nack <= nack_mask[wr_ord];
          wr_ord    <= wr_ord + 1;
        end else begin
          core_nack <= 1'b0;
        end
      end else if (core_busy && !hang) begin
        if (busy_left == 0) core_busy <= 1'b0;
        else busy_left <= busy_left - 1;
      end
    end
  end

  // Scoreboard
  typedef struct packed { logic [2:0] cmd; logic [7:0] data; } cmd_t;
  typedef struct packed { logic [1:0] err; logic [7:0] rdata; } rsp_t;
  cmd_t exp_cmds[$];
  rsp_t exp_rsps[$];

  int cyc = 0;
  int last_cmd_cyc = 0;
  int rsp_cyc = 0;
  int rsp_count = 0;
  bit ready_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cmd_t e;
    rsp_t r;
    if (ready_chk) begin
      chk("ready_after_rsp", 32'(req_ready), 32'd1);
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      ready_chk = 1'b0;
    end
    if (core_cmd != 3'd0) begin
      last_cmd_cyc = cyc;
      if (exp_cmds.size() == 0) begin
        chk("extra_cmd", 32'(core_cmd), 32'd0);
      end else begin
        e = exp_cmds.pop_front();
        chk("cmd", 32'(core_cmd), 32'(e.cmd));
        if (e.cmd == C_WRITE) chk("wdata", 32'(core_wdata), 32'(e.data));
      end
    end
    if (rsp_valid === 1'b1) begin
      rsp_cyc = cyc;
      rsp_count++;
      ready_chk = 1'b1;
      if (exp_rsps.size() == 0) begin
        chk("extra_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        r = exp_rsps.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
      end
    end
  end

  typedef struct {
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  wdata;
    logic [7:0]  mrdata;
    logic [31:0] nack_mask;
    int          busy_len;
    bit          hang;
    logic [1:0]  exp_err;
    logic [7:0]  exp_rdata;
    int          exp_lat;
  } vec_t;

  function automatic cmd_t spec_step(input vec_t v, input int s);
    cmd_t c;
    c = '{cmd: C_STOP, data: 8'h00};
    if (v.rw) begin
      case (s)
        0, 3: c.cmd = C_START;
        1: c = '{cmd: C_WRITE, data: {v.dev, 1'b0}};
        2: c = '{cmd: C_WRITE, data: v.rg};
        4: c = '{cmd: C_WRITE, data: {v.dev, 1'b1}};
        5: c.cmd = C_RNACK;
        default: c.cmd = C_STOP;
      endcase
    end else begin
      case (s)
        0: c.cmd = C_START;
        1: c = '{cmd: C_WRITE, data: {v.dev, 1'b0}};
        2: c = '{cmd: C_WRITE, data: v.rg};
        3: c = '{cmd: C_WRITE, data: v.wdata};
        default: c.cmd = C_STOP;
      endcase
    end
    return c;
  endfunction

  // Expected command stream, including NACK aborts and address retries.
  task automatic push_expect(input vec_t v);
    int   wr;
    int   tries;
    int   n;
    bit   done;
    bit   restart;
    cmd_t c;
    wr = 0; tries = 0; done = 1'b0;
    n = v.rw ? 7 : 5;
    while (!done) begin
      restart = 1'b0;
      for (int s = 0; s < n && !done && !restart; s++) begin
        c = spec_step(v, s);
        exp_cmds.push_back(c);
        if (c.cmd == C_STOP) done = 1'b1;
        if (c.cmd == C_WRITE) begin
          if (v.nack_mask[wr]) begin
            exp_cmds.push_back('{cmd: C_STOP, data: 8'h00});
            if (RETRY_EN && s == 1 && tries < int'(RETRIES)) begin
              tries++;
              restart = 1'b1;
            end else begin
              done = 1'b1;
            end
          end
          wr++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [1:0] prev_err = 2'd0;
  logic [7:0] prev_rdata = 8'h00;

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (req_ready !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
  endtask

  task automatic drive_req(input logic rw, input logic [6:0] d, input logic [7:0] r,
                           input logic [7:0] w);
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = d;
    req_reg   = r;
    req_wdata = w;
    tick();
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_dev   = 7'($urandom);
    req_reg   = 8'($urandom);
    req_wdata = 8'($urandom);
    chk("ready_drop", 32'(req_ready), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int acc_cyc;
    int n0;
    int budget;
    busy_len    = v.busy_len;
    nack_mask   = v.nack_mask;
    model_rdata = v.mrdata;
    hang        = v.hang;
    chk("hold_err", 32'(rsp_err), 32'(prev_err));
    chk("hold_rdata", 32'(rsp_rdata), 32'(prev_rdata));
    if (v.hang) exp_cmds.push_back('{cmd: C_START, data: 8'h00});
    else push_expect(v);
    exp_rsps.push_back('{err: v.exp_err, rdata: v.exp_rdata});
    wait_ready();
    acc_cyc = cyc;
    n0 = rsp_count;
    drive_req(v.rw, v.dev, v.rg, v.wdata);
    budget = 0;
    while (rsp_count == n0 && budget < 3000) begin
      tick();
      budget++;
    end
    chk("rsp_seen", 32'(rsp_count - n0), 32'd1);
    if (v.exp_lat != 0) chk("latency", 32'(rsp_cyc - acc_cyc), 32'(v.exp_lat));
    if (v.hang) begin
      chk("timeout_lat", 32'(rsp_cyc - last_cmd_cyc), 32'(TIMEOUT + 1));
      hang = 1'b0;
      budget = 0;
      while (core_busy !== 1'b0 && budget < 20) begin
        tick();
        budget++;
      end
    end
    chk("cmds_done", 32'(exp_cmds.size()), 32'd0);
    exp_cmds.delete();
    exp_rsps.delete();
    prev_err   = v.exp_err;
    prev_rdata = v.exp_rdata;
    tick();
  endtask

  vec_t vecs[10];
  int   nvec;

  initial begin
    int n0;
    int budget;
    nvec = 0;
    //             rw    dev    reg    wdata  mrdata mask   busy hang err   rdata  lat
    vecs[nvec++] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 32'h0, 1, 1'b0, 2'd0, 8'h00, 21};
    vecs[nvec++] = '{1'b1, 7'h50, 8'h20, 8'h00, 8'h3C, 32'h0, 1, 1'b0, 2'd0, 8'h3C, 29};
    vecs[nvec++] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 32'h2, 1, 1'b0, 2'd1, 8'h00, 16};
    vecs[nvec++] = '{1'b1, 7'h21, 8'h33, 8'h00, 8'h77, 32'h4, 1, 1'b0, 2'd1, 8'h00, 24};
    vecs[nvec++] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, 32'h0, 4, 1'b0, 2'd0, 8'h00, 36};
    vecs[nvec++] = '{1'b1, 7'h00, 8'h00, 8'h5A, 8'hFF, 32'h0, 3, 1'b0, 2'd0, 8'hFF, 43};
`ifdef I2C_SEQ_RETRY_EN
    vecs[nvec++] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 32'h3, 1, 1'b0, 2'd0, 8'h00, 43};
    vecs[nvec++] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 32'hF, 1, 1'b0, 2'd1, 8'h00, 45};
`else
    vecs[nvec++] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 32'h1, 1, 1'b0, 2'd1, 8'h00, 12};
`endif
    vecs[nvec++] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 32'h0, 1, 1'b1, 2'd2, 8'h00, 0};

    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd", 32'(core_cmd), 32'd0);
    chk("rst_core_wdata", 32'(core_wdata), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < nvec; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // Reset landing in the repeated-START step of a read.
    cur_tag = "reset_mid";
    busy_len    = 3;
    nack_mask   = 32'h0;
    model_rdata = 8'h5A;
    exp_cmds.push_back('{cmd: C_START, data: 8'h00});
    exp_cmds.push_back('{cmd: C_WRITE, data: 8'hA0});
    exp_cmds.push_back('{cmd: C_WRITE, data: 8'h20});
    exp_cmds.push_back('{cmd: C_START, data: 8'h00});
    wait_ready();
    n0 = rsp_count;
    drive_req(1'b1, 7'h50, 8'h20, 8'h00);
    budget = 0;
    while (exp_cmds.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    chk("step3_reached", 32'(exp_cmds.size()), 32'd0);
    reset = 1'b1;
    tick();
    chk("cmd_after_reset", 32'(core_cmd), 32'd0);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_back", 32'(req_ready), 32'd1);
    repeat (40) tick();
    chk("no_rsp", 32'(rsp_count - n0), 32'd0);
    chk("cmd_quiet", 32'(core_cmd), 32'd0);
    exp_cmds.delete();
    prev_err   = 2'd0;
    prev_rdata = 8'h00;

    cur_tag = "post_reset";
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
